fpu_cmd_sequencer: RTL and testbench
====================================

# fpu_cmd_sequencer

Upstream front-end for the memory-mapped FPU. Accepts floating-point operation requests (operand A, operand B, opcode) over a valid/ready stream and buffers them in a small FIFO. It then replays each request onto the FPU register bus as three writes: A at 0x00, B at 0x04, command at 0x08. It captures the FPU result and returns it on a valid/ready result stream, which frees software and other masters from hand-sequencing register writes.

## Interface
Parameters:
- `DEPTH`, default 4: request FIFO entries; power of two, ≥2.
- `ADDR_W`, default 13: FPU bus address width.

Ports:
- `clk` in 1: sole clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: FIFO can accept (`!full`).
- `req_a` in 32: operand A, IEEE-754 single.
- `req_b` in 32: operand B, IEEE-754 single.
- `req_op` in 2: 1 add, 2 sub, 3 mul, 0 invalid.
- `res_valid` out 1: result held.
- `res_ready` in 1: consumer takes result.
- `res_data` out 32: FPU result.
- `fpu_cs` out 1: FPU chip_select.
- `fpu_addr` out ADDR_W: FPU address.
- `fpu_wdata` out 32: FPU data_in.
- `fpu_rdata` in 32: FPU data_out.
- `busy` out 1: FSM not IDLE or FIFO not empty.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- FIFO: push on `req_valid && req_ready`. Pop only as described below. Push and pop in the same cycle leave `level` unchanged. Pointers wrap modulo DEPTH. No push when full, even if a pop occurs that cycle.
- FSM states: IDLE, WR_A, WR_B, WR_CMD, CAPT, DONE.
- IDLE: if `level != 0`, pop the head into the working registers, then go to WR_A. Otherwise stay in IDLE.
- WR_A: `fpu_cs=1`, addr 0x00, wdata = A. Next state WR_B.
- WR_B: `fpu_cs=1`, addr 0x04, wdata = B. Next state WR_CMD.
- WR_CMD: `fpu_cs=1`, addr 0x08, wdata = {30'b0, op}. Op 0 is passed through unchanged; the FPU answers 0x7FC00000. Next state CAPT.
- CAPT: `fpu_cs=0`. Register `fpu_rdata` into `res_data`. Next state DONE.
- DONE: `res_valid=1`. `res_data` is stable until the handshake completes. On `res_ready`:
  - if `level != 0`, pop and go to WR_A;
  - otherwise go to IDLE.
- In every state other than WR_A, WR_B and WR_CMD: `fpu_cs=0`, `fpu_addr=0`, `fpu_wdata=0`.
- Bus outputs are Moore: decoded from the state register and the working registers only, with no path from `req_*` or `res_ready`.
- Reset clears the FIFO, the working registers and `res_data`, and forces IDLE. All outputs read 0 except `req_ready=1`. A reset mid-sequence abandons the operation. The FPU shares this reset, so its registers are cleared with it.

## Timing
- Accept in cycle n with FIFO empty and FSM in IDLE:
  - n+1: IDLE pop;
  - n+2: WR_A;
  - n+3: WR_B;
  - n+4: WR_CMD (the FPU registers its result at the end of this cycle);
  - n+5: CAPT;
  - n+6: `res_valid=1`.
- Latency is therefore 6 cycles accept-to-valid.
- Back-to-back throughput with `res_ready=1` is one result per 5 cycles (DONE→WR_A).
- With `res_ready=0`, up to DEPTH+1 requests are absorbed: DEPTH queued plus one in the working registers.

## Configuration
- `FPU_SEQ_TAG_EN` defined: adds `req_tag` (in, 4) and `res_tag` (out, 4).
  - The tag is stored per FIFO entry and travels with its request.
  - `res_tag` is valid with `res_valid` and is 0 on reset.
- Not defined: the tag ports and storage are absent. Behaviour and timing are otherwise identical.

## Test plan
- Add: A=0x3F800000, B=0x40000000, op=1 into an idle block → bus writes at 0x00/0x04/0x08 in cycles n+2..n+4; `res_valid` at n+6 with `res_data`=0x40400000.
- Mul and sub back-to-back: 0x40000000×0x40400000 op 3 → 0x40C00000, then 0x3F800000−0x3F800000 op 2 → 0x00000000. Results in order, 5 cycles apart with `res_ready=1`.
- Invalid op 0 with any operands → `res_data`=0x7FC00000; the FSM returns to IDLE normally.
- Backpressure: `res_ready=0`, push continuously → DEPTH+1 accepts, then `req_ready=0` and `level`=DEPTH. Releasing `res_ready` drains all results in FIFO order. A simultaneous push and pop at `level`=2 leaves `level`=2.
- Reset asserted during WR_B → next cycle `fpu_cs=0`, `res_valid=0`, `level=0`, `busy=0`, `req_ready=1`. The next request completes normally with 6-cycle latency.
- With `FPU_SEQ_TAG_EN`: tags 0x3, 0xA, 0x5 on three requests → `res_tag` returns 0x3, 0xA, 0x5 paired with their results.

Source files
------------

// File: rtl/fpu_cmd_sequencer.sv
// Request FIFO plus sequencer that replays each FPU request as A/B/command register writes.
// Define FPU_SEQ_TAG_EN to add a 4-bit tag that travels with each request to its result.
module fpu_cmd_sequencer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 13
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [31:0]               req_a,
   input  logic [31:0]               req_b,
   input  logic [1:0]                req_op,
`ifdef FPU_SEQ_TAG_EN
   input  logic [3:0]                req_tag,
   output logic [3:0]                res_tag,
`endif
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [31:0]               res_data,
   output logic                      fpu_cs,
   output logic [ADDR_W-1:0]         fpu_addr,
   output logic [31:0]               fpu_wdata,
   input  logic [31:0]               fpu_rdata,
   output logic                      busy,
   output logic [$clog2(DEPTH):0]    level
);

   // state  | meaning
   // IDLE   | waiting for a queued request
   // WR_A   | writing operand A to 0x00
   // WR_B   | writing operand B to 0x04
   // WR_CMD | writing opcode to 0x08, FPU computes
   // CAPT   | latching FPU result
   // DONE   | result offered on the result stream
   typedef enum logic [2:0] {IDLE, WR_A, WR_B, WR_CMD, CAPT, DONE} state_t;

   localparam int           PW   = $clog2(DEPTH);
   localparam logic [PW:0]  FULL = (PW+1)'(DEPTH);

   state_t          state, state_nxt;
   logic [31:0]     mem_a  [DEPTH];
   logic [31:0]     mem_b  [DEPTH];
   logic [1:0]      mem_op [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [PW:0]     count;
   logic            push, pop;
   logic [31:0]     cur_a, cur_b;
   logic [1:0]      cur_op;

   assign req_ready = (count != FULL);
   assign push      = req_valid && req_ready;
   assign level     = count;
   assign busy      = (state != IDLE) || (count != '0);
   assign res_valid = (state == DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr]  <= req_a;
         mem_b[wr_ptr]  <= req_b;
         mem_op[wr_ptr] <= req_op;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               pop       = 1'b1;
               state_nxt = WR_A;
            end
         end
         WR_A:   state_nxt = WR_B;
         WR_B:   state_nxt = WR_CMD;
         WR_CMD: state_nxt = CAPT;
         CAPT:   state_nxt = DONE;
         DONE: begin
            if (res_ready) begin
               if (count != '0) begin
                  pop       = 1'b1;
                  state_nxt = WR_A;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_a    <= '0;
         cur_b    <= '0;
         cur_op   <= '0;
         res_data <= '0;
      end else begin
         if (pop) begin
            cur_a  <= mem_a[rd_ptr];
            cur_b  <= mem_b[rd_ptr];
            cur_op <= mem_op[rd_ptr];
         end
         if (state == CAPT) res_data <= fpu_rdata;
      end
   end

`ifdef FPU_SEQ_TAG_EN
   logic [3:0] mem_tag [DEPTH];
   logic [3:0] cur_tag;

   always_ff @(posedge clk) begin
      if (push) mem_tag[wr_ptr] <= req_tag;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_tag <= '0;
         res_tag <= '0;
      end else begin
         if (pop)            cur_tag <= mem_tag[rd_ptr];
         if (state == CAPT)  res_tag <= cur_tag;
      end
   end
`endif

   // Bus is Moore: only state and working registers feed it.
   always_comb begin
      fpu_cs    = 1'b0;
      fpu_addr  = '0;
      fpu_wdata = '0;
      case (state)
         WR_A: begin
            fpu_cs    = 1'b1;
            fpu_addr  = ADDR_W'(8'h00);
            fpu_wdata = cur_a;
         end
         WR_B: begin
            fpu_cs    = 1'b1;
            fpu_addr  = ADDR_W'(8'h04);
            fpu_wdata = cur_b;
         end
         WR_CMD: begin
            fpu_cs    = 1'b1;
            fpu_addr  = ADDR_W'(8'h08);
            fpu_wdata = {30'b0, cur_op};
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// Scoreboard bench for fpu_cmd_sequencer with a small register-mapped FPU model.
// Tag checks are included when FPU_SEQ_TAG_EN is defined.
`timescale 1ns/1ps
module tb_fpu_cmd_sequencer;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 13;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid, req_ready;
   logic [31:0]       req_a, req_b;
   logic [1:0]        req_op;
   logic              res_valid, res_ready;
   logic [31:0]       res_data;
   logic              fpu_cs;
   logic [ADDR_W-1:0] fpu_addr;
   logic [31:0]       fpu_wdata, fpu_rdata;
   logic              busy;
   logic [2:0]        level;
`ifdef FPU_SEQ_TAG_EN
   logic [3:0]        req_tag, res_tag;
`endif

   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   int          ntag  = 0;
   int          hs_cyc [$];
   logic [35:0] sb [$];
   logic [35:0] sb_e;
   logic [3:0]  tag_list [8] = '{4'h3, 4'hA, 4'h5, 4'hC, 4'h1, 4'h6, 4'h9, 4'hE};
   logic [31:0] fa, fb;

   fpu_cmd_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
`ifdef FPU_SEQ_TAG_EN
      .req_tag(req_tag), .res_tag(res_tag),
`endif
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .fpu_cs(fpu_cs), .fpu_addr(fpu_addr), .fpu_wdata(fpu_wdata),
      .fpu_rdata(fpu_rdata), .busy(busy), .level(level)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Known results for the directed operand set; anything else reads back as a marker value.
   function automatic logic [31:0] fpu_calc(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
      if (op == 2'd0) return 32'h7FC00000;
      case ({a, b, op})
         {32'h3F800000, 32'h40000000, 2'd1}: return 32'h40400000;
         {32'h40000000, 32'h40400000, 2'd3}: return 32'h40C00000;
         {32'h3F800000, 32'h3F800000, 2'd2}: return 32'h00000000;
         {32'h40400000, 32'h3F800000, 2'd2}: return 32'h40000000;
         {32'h3F800000, 32'h40000000, 2'd2}: return 32'hBF800000;
         {32'h40000000, 32'h40000000, 2'd1}: return 32'h40800000;
         {32'h40000000, 32'h3F800000, 2'd2}: return 32'h3F800000;
         {32'h3F800000, 32'h3F800000, 2'd1}: return 32'h40000000;
         {32'h40400000, 32'h40400000, 2'd3}: return 32'h41100000;
         default:                            return 32'hDEADBEEF;
      endcase
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         fa        <= '0;
         fb        <= '0;
         fpu_rdata <= '0;
      end else if (fpu_cs) begin
         case (fpu_addr)
            13'h000: fa <= fpu_wdata;
            13'h004: fb <= fpu_wdata;
            13'h008: fpu_rdata <= fpu_calc(fa, fb, fpu_wdata[1:0]);
            default: ;
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && res_valid && res_ready) begin
         hs_cyc.push_back(cyc);
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected: actual %h required no result", res_data);
         end else begin
            sb_e = sb.pop_front();
            chk("res_data", res_data, sb_e[31:0]);
`ifdef FPU_SEQ_TAG_EN
            chk("res_tag", 32'(res_tag), 32'(sb_e[35:32]));
`endif
         end
      end
   end

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      req_op    = op;
`ifdef FPU_SEQ_TAG_EN
      req_tag   = tag_list[ntag % 8];
`endif
   endtask

   task automatic push_exp(input logic [31:0] exp);
      sb.push_back({tag_list[ntag % 8], exp});
      ntag++;
   endtask

   // Called at posedge+1; FIFO must have room.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic [31:0] exp);
      drive(a, b, op);
      push_exp(exp);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // Single request into an idle block with cycle-exact bus checks; returns at negedge of n+6.
   task automatic check_seq(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                            input logic [31:0] exp);
      send(a, b, op, exp);
      @(negedge clk);
      chk("n1_cs", 32'(fpu_cs), 32'd0);
      @(negedge clk);
      chk("wr_a_cs", 32'(fpu_cs), 32'd1);
      chk("wr_a_addr", 32'(fpu_addr), 32'h00);
      chk("wr_a_data", fpu_wdata, a);
      @(negedge clk);
      chk("wr_b_cs", 32'(fpu_cs), 32'd1);
      chk("wr_b_addr", 32'(fpu_addr), 32'h04);
      chk("wr_b_data", fpu_wdata, b);
      @(negedge clk);
      chk("wr_cmd_cs", 32'(fpu_cs), 32'd1);
      chk("wr_cmd_addr", 32'(fpu_addr), 32'h08);
      chk("wr_cmd_data", fpu_wdata, {30'b0, op});
      @(negedge clk);
      chk("capt_cs", 32'(fpu_cs), 32'd0);
      chk("capt_addr", 32'(fpu_addr), 32'd0);
      chk("capt_valid", 32'(res_valid), 32'd0);
      @(negedge clk);
      chk("latency6_valid", 32'(res_valid), 32'd1);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", 32'(sb.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   // Called at posedge+1 with res_ready=0; accepts one result, optionally pushing alongside.
   task automatic take_one(input bit with_push, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op, input logic [31:0] exp);
      int n = 0;
      while (!res_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("take_timeout", 32'(res_valid), 32'd1);
      @(posedge clk); #1;
      res_ready = 1'b1;
      if (with_push) begin
         drive(a, b, op);
         push_exp(exp);
      end
      @(posedge clk); #1;
      res_ready = 1'b0;
      req_valid = 1'b0;
   endtask

   logic [31:0] bp_a   [6] = '{32'h40000000, 32'h40000000, 32'h3F800000,
                               32'h40400000, 32'h3F800000, 32'h3F800000};
   logic [31:0] bp_b   [6] = '{32'h40000000, 32'h3F800000, 32'h3F800000,
                               32'h40400000, 32'h40000000, 32'h40000000};
   logic [1:0]  bp_op  [6] = '{2'd1, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1};
   logic [31:0] bp_exp [6] = '{32'h40800000, 32'h3F800000, 32'h40000000,
                               32'h41100000, 32'hBF800000, 32'h40400000};

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required completion");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1);
   end

   initial begin
      int acc;
      int k;
      int n;
      bit rdy;
      reset     = 1'b1;
      req_valid = 1'b0;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      res_ready = 1'b1;
`ifdef FPU_SEQ_TAG_EN
      req_tag   = '0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_data", res_data, 32'd0);
      chk("rst_fpu_cs", 32'(fpu_cs), 32'd0);
      chk("rst_fpu_addr", 32'(fpu_addr), 32'd0);
      chk("rst_fpu_wdata", fpu_wdata, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
`ifdef FPU_SEQ_TAG_EN
      chk("rst_res_tag", 32'(res_tag), 32'd0);
`endif
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // add 1+2 with cycle-exact bus timing
      check_seq(32'h3F800000, 32'h40000000, 2'd1, 32'h40400000);
      @(posedge clk); #1;
      wait_drain();

      // back-to-back mul/sub, then non-commutative subs
      hs_cyc.delete();
      send(32'h40000000, 32'h40400000, 2'd3, 32'h40C00000);
      send(32'h3F800000, 32'h3F800000, 2'd2, 32'h00000000);
      wait_drain();
      chk("b2b_count", 32'(hs_cyc.size()), 32'd2);
      if (hs_cyc.size() >= 2) chk("b2b_spacing", 32'(hs_cyc[1] - hs_cyc[0]), 32'd5);
      send(32'h40400000, 32'h3F800000, 2'd2, 32'h40000000);
      send(32'h3F800000, 32'h40000000, 2'd2, 32'hBF800000);
      wait_drain();

      // invalid opcode, then FSM returns to idle
      check_seq(32'h12345678, 32'h9ABCDEF0, 2'd0, 32'h7FC00000);
      @(negedge clk);
      chk("op0_idle_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;

      // backpressure fill
      res_ready = 1'b0;
      acc = 0;
      k   = 0;
      for (int i = 0; i < 12; i++) begin
         drive(bp_a[k], bp_b[k], bp_op[k]);
         @(negedge clk);
         rdy = req_ready;
         @(posedge clk); #1;
         if (rdy) begin
            acc++;
            push_exp(bp_exp[k]);
            if (k < 4) k++;
         end
      end
      req_valid = 1'b0;
      @(negedge clk);
      chk("bp_accepts", 32'(acc), 32'(DEPTH + 1));
      chk("bp_level_full", 32'(level), 32'(DEPTH));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      take_one(1'b0, 32'd0, 32'd0, 2'd0, 32'd0);
      take_one(1'b0, 32'd0, 32'd0, 2'd0, 32'd0);
      @(negedge clk);
      chk("bp_level_two", 32'(level), 32'd2);
      @(posedge clk); #1;
      take_one(1'b1, bp_a[5], bp_b[5], bp_op[5], bp_exp[5]);
      @(negedge clk);
      chk("push_pop_level", 32'(level), 32'd2);
      @(posedge clk); #1;
      res_ready = 1'b1;
      wait_drain();

      // reset during WR_B
      send(32'h40000000, 32'h40000000, 2'd1, 32'h40800000);
      n = 0;
      while (!(fpu_cs && fpu_addr == 13'h004) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("reach_wr_b", 32'(fpu_addr), 32'h04);
      reset = 1'b1;
      sb.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_cs", 32'(fpu_cs), 32'd0);
      chk("mid_rst_valid", 32'(res_valid), 32'd0);
      chk("mid_rst_level", 32'(level), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      check_seq(32'h3F800000, 32'h40000000, 2'd1, 32'h40400000);
      @(posedge clk); #1;
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
